// File: rtl/switch_debounce_pkg.sv
// switch_pkg: shared constants and sizing helper for the switch debounce front end
package switch_pkg;
  localparam int N_SW = 16;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_TICK_DIV = 100000;
  localparam int DEFAULT_STABLE_TICKS = 10;
  function automatic int cnt_width(input int stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction
endpackage

// File: rtl/switch_debounce_if.sv
// switch_debounce_if: raw switch inputs and conditioned outputs of the debounce stage
interface switch_debounce_if import switch_pkg::*; #(
  parameter int N = N_SW
);
  logic [N-1:0] SW;
  logic [N-1:0] SW_DB;
  logic [N-1:0] SW_CHG;
  logic TICK;
  modport master(output SW, input SW_DB, SW_CHG, TICK);
  modport slave(input SW, output SW_DB, SW_CHG, TICK);
endinterface

// File: rtl/switch_debounce_bit.sv
// debounce_bit: synchroniser, stability counter and registered state/strobe for one switch
module debounce_bit import switch_pkg::*; #(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic tick,
  output logic db,
  output logic chg
);
  localparam int CW = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt;
  logic sync;
  assign sync = sync_q[SYNC_STAGES-1];
  // plain flop chain into the clk domain
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  // count ticks of disagreement; any agreement restarts the window
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      db  <= 1'b0;
      chg <= 1'b0;
    end else begin
      chg <= 1'b0;
      if (sync == db) cnt <= '0;
      else if (tick && cnt == LAST) begin
        db  <= sync;
        cnt <= '0;
        chg <= 1'b1;
      end else if (tick) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/switch_debounce.sv
// switch_debounce: shared tick prescaler feeding N independent switch debouncers
module switch_debounce import switch_pkg::*; #(
  parameter int N = N_SW,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
  input logic clk,
  input logic rst,
  switch_debounce_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  logic [PW-1:0] pre;
  logic tick;
  logic [N-1:0] db, chg;
  assign tick = pre == LAST;
  assign bus.TICK = tick;
  assign bus.SW_DB = db;
  assign bus.SW_CHG = chg;
  // free-running prescaler, wraps at TICK_DIV-1
  always_ff @(posedge clk or posedge rst)
    if (rst) pre <= '0;
    else pre <= tick ? '0 : pre + 1'b1;
  for (genvar i = 0; i < N; i++) begin : g_bit
    debounce_bit #(.SYNC_STAGES(SYNC_STAGES), .STABLE_TICKS(STABLE_TICKS)) u_bit (
      .clk(clk),
      .rst(rst),
      .raw(bus.SW[i]),
      .tick(tick),
      .db(db[i]),
      .chg(chg[i])
    );
  end
endmodule
